// File: rtl/whac_a_mole_engine.sv
// Whack-a-mole game engine: concurrent mole slots with lifetime timers, combo scoring,
// lives and game-over sequencing between the RNG, tick prescaler, switches and display.
module whac_a_mole_engine #(
    parameter int unsigned N_HOLES    = 18,
    parameter int unsigned MAX_MOLES  = 3,
    parameter int unsigned LIVES      = 3,
    parameter int unsigned SCORE_W    = 16,
    parameter int unsigned COMBO_STEP = 5,
    parameter int unsigned LIFE0      = 1500,
    parameter int unsigned LIFE1      = 1000,
    parameter int unsigned LIFE2      = 600,
    localparam int unsigned IW        = $clog2(N_HOLES),
    localparam int unsigned LW        = $clog2(LIVES + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_btn,
    input  logic               reset_btn,
    input  logic [1:0]         level,
    input  logic               tick,
    input  logic               rng_valid,
    input  logic [IW-1:0]      rng_index,
    output logic               rng_ready,
    input  logic [N_HOLES-1:0] switches,
    output logic [N_HOLES-1:0] mole_mask,
    output logic [SCORE_W-1:0] score,
    output logic [LW-1:0]      lives_left,
    output logic [7:0]         combo,
    output logic [3:0]         multiplier,
    output logic [1:0]         game_state
);

    localparam int unsigned TW = 16;
    localparam int unsigned CW = $clog2(MAX_MOLES + 1);
    localparam int unsigned AW = SCORE_W + 12;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PLAY = 2'b01,
        S_OVER = 2'b10
    } state_t;

    state_t               state_q, state_n;
    logic [1:0]           lvl_q, lvl_n;
    logic [MAX_MOLES-1:0] act_q, act_n;
    logic [IW-1:0]        hole_q  [MAX_MOLES];
    logic [IW-1:0]        hole_n  [MAX_MOLES];
    logic [TW-1:0]        timer_q [MAX_MOLES];
    logic [TW-1:0]        timer_n [MAX_MOLES];
    logic [N_HOLES-1:0]   mask_q, mask_n;
    logic [SCORE_W-1:0]   score_q, score_n;
    logic [LW-1:0]        lives_q, lives_n;
    logic [7:0]           combo_q, combo_n;
    logic                 start_prev, reset_prev;
    logic [N_HOLES-1:0]   sw_prev;

    logic                 start_edge, reset_edge;
    logic [N_HOLES-1:0]   sw_edge;
    logic [MAX_MOLES-1:0] hit_v, exp_v;
    logic [CW-1:0]        act_cnt, hit_cnt, exp_cnt, limit;
    logic                 wrong;
    logic [TW-1:0]        life;
    logic [3:0]           base;
    logic [8:0]           mul_sum;
    logic [AW-1:0]        score_sum;
    logic [8:0]           combo_sum;

    assign start_edge = start_btn & ~start_prev;
    assign reset_edge = reset_btn & ~reset_prev;
    assign sw_edge    = switches & ~sw_prev;

    assign mole_mask  = mask_q;
    assign score      = score_q;
    assign lives_left = lives_q;
    assign combo      = combo_q;
    assign game_state = state_q;

    // Per-slot hit/expiry detection, occupancy counts and level-dependent constants.
    always_comb begin
        hit_v   = '0;
        exp_v   = '0;
        act_cnt = '0;
        hit_cnt = '0;
        exp_cnt = '0;
        for (int i = 0; i < MAX_MOLES; i++) begin
            hit_v[i] = act_q[i] & sw_edge[hole_q[i]];
            exp_v[i] = act_q[i] & tick & (timer_q[i] == TW'(1)) & ~hit_v[i];
            act_cnt  = act_cnt + CW'(act_q[i]);
            hit_cnt  = hit_cnt + CW'(hit_v[i]);
            exp_cnt  = exp_cnt + CW'(exp_v[i]);
        end
        wrong = |(sw_edge & ~mask_q);
        case (lvl_q)
            2'd0:    begin limit = CW'(1);         base = 4'd1; life = TW'(LIFE0); end
            2'd1:    begin limit = CW'(2);         base = 4'd3; life = TW'(LIFE1); end
            default: begin limit = CW'(MAX_MOLES); base = 4'd5; life = TW'(LIFE2); end
        endcase
        mul_sum    = 9'(base) + 9'(combo_q / 8'(COMBO_STEP));
        multiplier = (mul_sum > 9'd15) ? 4'd15 : mul_sum[3:0];
        rng_ready  = (state_q == S_PLAY) && (act_cnt < limit);
    end

    // Next-state and datapath update; a reset-button edge overrides everything.
    always_comb begin
        logic found;
        state_n   = state_q;
        lvl_n     = lvl_q;
        act_n     = act_q;
        hole_n    = hole_q;
        timer_n   = timer_q;
        score_n   = score_q;
        lives_n   = lives_q;
        combo_n   = combo_q;
        mask_n    = '0;
        score_sum = '0;
        combo_sum = '0;
        found     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    lvl_n   = (level == 2'd3) ? 2'd2 : level;
                    score_n = '0;
                    lives_n = LW'(LIVES);
                    combo_n = '0;
                    state_n = S_PLAY;
                end
            end
            S_PLAY: begin
                for (int i = 0; i < MAX_MOLES; i++) begin
                    if (hit_v[i] || exp_v[i]) begin
                        act_n[i]   = 1'b0;
                        timer_n[i] = '0;
                    end else if (act_q[i] && tick) begin
                        timer_n[i] = timer_q[i] - TW'(1);
                    end
                end
                if (hit_cnt != '0) begin
                    score_sum = AW'(score_q) + AW'(hit_cnt) * AW'(10) * AW'(multiplier);
                    score_n   = (score_sum[AW-1:SCORE_W] != '0) ? {SCORE_W{1'b1}}
                                                                : score_sum[SCORE_W-1:0];
                    combo_sum = 9'(combo_q) + 9'(hit_cnt);
                    combo_n   = combo_sum[8] ? 8'd255 : combo_sum[7:0];
                end
                if ((exp_cnt != '0) || wrong)
                    combo_n = '0;
                if (exp_cnt != '0)
                    lives_n = (8'(exp_cnt) >= 8'(lives_q)) ? '0
                                                           : LW'(8'(lives_q) - 8'(exp_cnt));
                // Spawns only fill slots that were already free at cycle start.
                if (rng_valid && rng_ready && (32'(rng_index) < N_HOLES)) begin
                    if (!mask_q[rng_index]) begin
                        for (int i = 0; i < MAX_MOLES; i++) begin
                            if (!act_q[i] && !found) begin
                                found      = 1'b1;
                                act_n[i]   = 1'b1;
                                hole_n[i]  = rng_index;
                                timer_n[i] = life;
                            end
                        end
                    end
                end
                if ((exp_cnt != '0) && (lives_n == '0)) begin
                    state_n = S_OVER;
                    act_n   = '0;
                    for (int i = 0; i < MAX_MOLES; i++) timer_n[i] = '0;
                end
            end
            default: ;
        endcase

        if (reset_edge) begin
            state_n = S_IDLE;
            act_n   = '0;
            score_n = '0;
            combo_n = '0;
            lives_n = '0;
            for (int i = 0; i < MAX_MOLES; i++) timer_n[i] = '0;
        end

        for (int i = 0; i < MAX_MOLES; i++)
            if (act_n[i]) mask_n[hole_n[i]] = 1'b1;
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            lvl_q      <= '0;
            act_q      <= '0;
            mask_q     <= '0;
            score_q    <= '0;
            lives_q    <= '0;
            combo_q    <= '0;
            start_prev <= 1'b0;
            reset_prev <= 1'b0;
            sw_prev    <= '0;
            for (int i = 0; i < MAX_MOLES; i++) begin
                hole_q[i]  <= '0;
                timer_q[i] <= '0;
            end
        end else begin
            state_q    <= state_n;
            lvl_q      <= lvl_n;
            act_q      <= act_n;
            mask_q     <= mask_n;
            score_q    <= score_n;
            lives_q    <= lives_n;
            combo_q    <= combo_n;
            start_prev <= start_btn;
            reset_prev <= reset_btn;
            sw_prev    <= switches;
            for (int i = 0; i < MAX_MOLES; i++) begin
                hole_q[i]  <= hole_n[i];
                timer_q[i] <= timer_n[i];
            end
        end
    end

endmodule

// File: tb/tb_whac_a_mole_engine.sv
// Scoreboard bench for whac_a_mole_engine: expectations queued at stimulus time,
// popped and compared against the DUT after the relevant clock edge.
module tb_whac_a_mole_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_btn = 1'b0;
    logic        reset_btn = 1'b0;
    logic [1:0]  level = 2'd0;
    logic        tick = 1'b0;
    logic        rng_valid = 1'b0;
    logic [4:0]  rng_index = 5'd0;
    logic        rng_ready;
    logic [17:0] switches = '0;
    logic [17:0] mole_mask;
    logic [15:0] score;
    logic [1:0]  lives_left;
    logic [7:0]  combo;
    logic [3:0]  multiplier;
    logic [1:0]  game_state;

    int checks = 0;
    int errors = 0;
    string       tag_q[$];
    logic [31:0] exp_q[$];
    int m_score, m_combo, m_level;

    whac_a_mole_engine dut (
        .clk(clk), .rst_n(rst_n), .start_btn(start_btn), .reset_btn(reset_btn),
        .level(level), .tick(tick), .rng_valid(rng_valid), .rng_index(rng_index),
        .rng_ready(rng_ready), .switches(switches), .mole_mask(mole_mask),
        .score(score), .lives_left(lives_left), .combo(combo),
        .multiplier(multiplier), .game_state(game_state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        if (exp_q.size() == 0) check_eq("sb_underflow", 32'd1, 32'd0);
        else check_eq(tag_q.pop_front(), obs, exp_q.pop_front());
    endtask

    function automatic int exp_mult(input int lv, input int c);
        int r;
        r = ((lv == 0) ? 1 : (lv == 1) ? 3 : 5) + c / 5;
        return (r > 15) ? 15 : r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_reset_values(input string pfx);
        sb_push({pfx, "_state"}, 0); sb_push({pfx, "_mask"}, 0); sb_push({pfx, "_score"}, 0);
        sb_push({pfx, "_lives"}, 0); sb_push({pfx, "_combo"}, 0); sb_push({pfx, "_mult"}, 1);
        sb_push({pfx, "_ready"}, 0);
    endtask

    task automatic pop_reset_values();
        sb_pop(32'(game_state)); sb_pop(32'(mole_mask)); sb_pop(32'(score));
        sb_pop(32'(lives_left)); sb_pop(32'(combo)); sb_pop(32'(multiplier));
        sb_pop(32'(rng_ready));
    endtask

    task automatic start_game(input int lv);
        level = 2'(lv);
        m_level = (lv == 3) ? 2 : lv;
        m_score = 0;
        m_combo = 0;
        sb_push("start_state", 1); sb_push("start_lives", 3);
        sb_push("start_score", 0); sb_push("start_ready", 1);
        start_btn = 1'b1;
        step();
        start_btn = 1'b0;
        sb_pop(32'(game_state)); sb_pop(32'(lives_left));
        sb_pop(32'(score)); sb_pop(32'(rng_ready));
        step();
    endtask

    task automatic reset_game();
        reset_btn = 1'b1;
        step();
        reset_btn = 1'b0;
        step();
    endtask

    task automatic spawn(input int idx, input int exp_ready, input logic [17:0] exp_mask);
        sb_push("spawn_ready", 32'(exp_ready));
        sb_pop(32'(rng_ready));
        sb_push("spawn_mask", 32'(exp_mask));
        rng_valid = 1'b1;
        rng_index = 5'(idx);
        step();
        rng_valid = 1'b0;
        sb_pop(32'(mole_mask));
    endtask

    task automatic do_hit(input int h, input logic [17:0] exp_mask);
        m_score = m_score + 10 * exp_mult(m_level, m_combo);
        if (m_score > 65535) m_score = 65535;
        m_combo = (m_combo < 255) ? m_combo + 1 : 255;
        sb_push("hit_score", 32'(m_score)); sb_push("hit_combo", 32'(m_combo));
        sb_push("hit_mask", 32'(exp_mask));
        switches = '0;
        switches[h] = 1'b1;
        step();
        switches = '0;
        sb_pop(32'(score)); sb_pop(32'(combo)); sb_pop(32'(mole_mask));
        step();
    endtask

    initial begin
        // Power-on reset values
        step(); step();
        expect_reset_values("rst");
        pop_reset_values();
        rst_n = 1'b1;
        step();

        // Basic hit at level 0
        start_game(0);
        spawn(4, 1, 18'h00010);
        sb_push("lim1_ready", 0); sb_pop(32'(rng_ready));
        do_hit(4, 18'h0);

        // Combo and multiplier at level 2
        reset_game();
        start_game(2);
        for (int i = 0; i < 6; i++) begin
            spawn(i, 1, 18'(1) << i);
            do_hit(i, 18'h0);
            if (i == 4) begin
                sb_push("combo5_score", 250); sb_push("combo5_mult", 6);
                sb_pop(32'(score)); sb_pop(32'(multiplier));
            end
        end
        sb_push("combo6_score", 310); sb_pop(32'(score));

        // Invalid spawns and wrong whack
        spawn(7, 1, 18'h00080);
        spawn(20, 1, 18'h00080);
        spawn(7, 1, 18'h00080);
        sb_push("ww_combo", 0); sb_push("ww_score", 310);
        sb_push("ww_mask", 18'h00080); sb_push("ww_mult", 5);
        switches[0] = 1'b1;
        step();
        switches = '0;
        sb_pop(32'(combo)); sb_pop(32'(score)); sb_pop(32'(mole_mask)); sb_pop(32'(multiplier));
        m_combo = 0;
        step();

        // Hit lands on the expiry tick of the same slot
        tick = 1'b1;
        repeat (599) step();
        sb_push("pre_exp_mask", 18'h00080); sb_pop(32'(mole_mask));
        sb_push("hve_score", 360); sb_push("hve_lives", 3);
        sb_push("hve_mask", 0); sb_push("hve_combo", 1);
        switches[7] = 1'b1;
        step();
        tick = 1'b0;
        switches = '0;
        sb_pop(32'(score)); sb_pop(32'(lives_left)); sb_pop(32'(mole_mask)); sb_pop(32'(combo));
        step();

        // Mid-game reset button with three moles lit
        spawn(1, 1, 18'h00002);
        spawn(2, 1, 18'h00006);
        spawn(3, 1, 18'h0000E);
        sb_push("full_ready", 0); sb_pop(32'(rng_ready));
        sb_push("rb_state", 0); sb_push("rb_mask", 0); sb_push("rb_score", 0);
        sb_push("rb_lives", 0); sb_push("rb_combo", 0);
        reset_btn = 1'b1;
        step();
        reset_btn = 1'b0;
        sb_pop(32'(game_state)); sb_pop(32'(mole_mask)); sb_pop(32'(score));
        sb_pop(32'(lives_left)); sb_pop(32'(combo));
        step();

        // Lifetime expiry down to game over at level 1
        start_game(1);
        spawn(2, 1, 18'h00004);
        do_hit(2, 18'h0);
        spawn(5, 1, 18'h00020);
        spawn(6, 1, 18'h00060);
        sb_push("lim2_ready", 0); sb_pop(32'(rng_ready));
        tick = 1'b1;
        repeat (999) step();
        sb_push("life_lives", 3); sb_push("life_mask", 18'h00060);
        sb_pop(32'(lives_left)); sb_pop(32'(mole_mask));
        sb_push("dbl_lives", 1); sb_push("dbl_mask", 0); sb_push("dbl_combo", 0);
        sb_push("dbl_state", 1); sb_push("dbl_score", 30);
        step();
        sb_pop(32'(lives_left)); sb_pop(32'(mole_mask)); sb_pop(32'(combo));
        sb_pop(32'(game_state)); sb_pop(32'(score));
        spawn(9, 1, 18'h00200);
        repeat (999) step();
        sb_push("last_state", 1); sb_push("last_lives", 1);
        sb_pop(32'(game_state)); sb_pop(32'(lives_left));
        sb_push("over_state", 2); sb_push("over_mask", 0); sb_push("over_lives", 0);
        sb_push("over_score", 30); sb_push("over_ready", 0);
        step();
        tick = 1'b0;
        sb_pop(32'(game_state)); sb_pop(32'(mole_mask)); sb_pop(32'(lives_left));
        sb_pop(32'(score)); sb_pop(32'(rng_ready));
        sb_push("over_start_state", 2);
        start_btn = 1'b1;
        step();
        start_btn = 1'b0;
        sb_pop(32'(game_state));
        step();

        // Asynchronous rst_n mid-game
        reset_game();
        start_game(0);
        spawn(3, 1, 18'h00008);
        expect_reset_values("arst");
        rst_n = 1'b0;
        #2;
        pop_reset_values();
        step();
        rst_n = 1'b1;
        step();

        check_eq("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
